// File: rtl/seg7_scanner.sv
// seg7_scanner: time-multiplexed 8-digit 7-segment driver with per-slot blanking and frame snapshot
module seg7_scanner #(
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in [7:0],
  input  logic [7:0] digit_en,
  input  logic       lamp_test,
  output logic [6:0] seg_out,
  output logic [7:0] an_out,
  output logic       frame_done
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  typedef enum logic {BLANK, ON} slot_t;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [6:0] frame_buf [7:0];
  logic [7:0] en_snap;
  logic [6:0] seg_d;
  logic [7:0] an_d;
  slot_t st;
  always_comb begin
    st = (cnt < BLANK_END) ? BLANK : ON;
    an_d = (st == ON && en_snap[idx]) ? ~(8'b1 << idx) : 8'hFF;
    seg_d = (st == ON && en_snap[idx]) ? (lamp_test ? 7'h00 : frame_buf[idx]) : 7'h7F;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      frame_buf <= '{default: 7'h7F};
      en_snap <= '0;
      seg_out <= 7'h7F;
      an_out <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (cnt == LAST) idx <= idx + 1'b1;
      if (cnt == '0 && idx == 3'd0) begin
        frame_buf <= seg_in;
        en_snap <= digit_en;
      end
      seg_out <= seg_d;
      an_out <= an_d;
      frame_done <= (cnt == LAST) && (idx == 3'd7);
    end
  end
endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: scoreboard bench for seg7_scanner with DIGIT_CYCLES=8, BLANK_CYCLES=2
module tb_seg7_scanner;
  localparam int D = 8;
  localparam int B = 2;
  localparam int F = 8 * D;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] seg_in [7:0];
  logic [7:0] digit_en = 8'h00;
  logic lamp_test = 1'b0;
  logic [6:0] seg_out;
  logic [7:0] an_out;
  logic frame_done;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  int m_t = 0;
  logic [6:0] m_buf [7:0];
  logic [7:0] m_en;

  seg7_scanner #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_en(digit_en),
    .lamp_test(lamp_test), .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // reference model: frame position m_t in 0..F-1, pushes the output expected after each edge
  always @(posedge clk) begin
    int sl, ps;
    logic [15:0] e;
    sl = m_t / D;
    ps = m_t % D;
    e = {7'h7F, 8'hFF, 1'b0};
    if (!rst_n) begin
      exp_q.push_back(e);
      m_t <= 0;
      m_en <= 8'h00;
      for (int i = 0; i < 8; i++) m_buf[i] <= 7'h7F;
    end else begin
      if (ps >= B && m_en[sl]) e = {lamp_test ? 7'h00 : m_buf[sl], ~(8'b1 << sl), 1'b0};
      e[0] = (m_t == F - 1);
      exp_q.push_back(e);
      if (m_t == 0) begin
        m_buf <= seg_in;
        m_en <= digit_en;
      end
      m_t <= (m_t + 1) % F;
    end
  end

  task automatic test_reset();
    logic [15:0] e;
    for (int i = 0; i < 8; i++) seg_in[i] = 7'h40 + 7'(i);
    digit_en = 8'hFF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL reset_sb empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if ({seg_out, an_out, frame_done} !== e) begin
          errors++;
          $display("FAIL reset_sb k=%0d got %h/%h/%b exp %h/%h/%b", k, seg_out, an_out, frame_done, e[15:9], e[8:1], e[0]);
        end
      end
      checks++;
      if (seg_out !== 7'h7F || an_out !== 8'hFF || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_state got %h/%h/%b exp 7f/ff/0", seg_out, an_out, frame_done);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    logic [15:0] e;
    int lit [8];
    for (int j = 0; j < 8; j++) lit[j] = 0;
    for (int k = 1; k <= F; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL scan_sb empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if ({seg_out, an_out, frame_done} !== e) begin
          errors++;
          $display("FAIL scan_sb k=%0d got %h/%h/%b exp %h/%h/%b", k, seg_out, an_out, frame_done, e[15:9], e[8:1], e[0]);
        end
      end
      for (int j = 0; j < 8; j++) if (an_out == ~(8'b1 << j)) begin
        lit[j]++;
        checks++;
        if (seg_out !== 7'h40 + 7'(j)) begin
          errors++;
          $display("FAIL scan_seg digit=%0d got %h exp %h", j, seg_out, 7'h40 + 7'(j));
        end
      end
      if (k == 3) begin
        checks++;
        if (an_out !== 8'hFE || seg_out !== 7'h40) begin
          errors++;
          $display("FAIL scan_first_lit got %h/%h exp fe/40", an_out, seg_out);
        end
      end
    end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (lit[j] != D - B) begin errors++; $display("FAIL scan_lit digit=%0d got %0d exp %0d", j, lit[j], D - B); end
    end
  endtask

  task automatic test_frame_done();
    logic [15:0] e;
    int pulses = 0;
    int last_k = 0;
    for (int k = 1; k <= 3 * F; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL fd_sb empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if ({seg_out, an_out, frame_done} !== e) begin
          errors++;
          $display("FAIL fd_sb k=%0d got %h/%h/%b exp %h/%h/%b", k, seg_out, an_out, frame_done, e[15:9], e[8:1], e[0]);
        end
      end
      if (frame_done === 1'b1) begin
        pulses++;
        checks++;
        if (k - last_k != F || an_out !== 8'h7F) begin
          errors++;
          $display("FAIL fd_timing k=%0d gap=%0d an=%h exp gap %0d an 7f", k, k - last_k, an_out, F);
        end
        last_k = k;
      end
    end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL fd_count got %0d exp 3", pulses); end
  endtask

  task automatic test_mid_update();
    logic [15:0] e;
    int seen = 0;
    for (int k = 1; k <= 2 * F; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL upd_sb empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if ({seg_out, an_out, frame_done} !== e) begin
          errors++;
          $display("FAIL upd_sb k=%0d got %h/%h/%b exp %h/%h/%b", k, seg_out, an_out, frame_done, e[15:9], e[8:1], e[0]);
        end
      end
      if (an_out === 8'hDF) begin
        seen++;
        checks++;
        if (seg_out !== (k <= F ? 7'h45 : 7'h12)) begin
          errors++;
          $display("FAIL upd_digit5 k=%0d got %h exp %h", k, seg_out, k <= F ? 7'h45 : 7'h12);
        end
      end
      if (k == 20) seg_in[5] = 7'h12;
    end
    checks++;
    if (seen != 2 * (D - B)) begin errors++; $display("FAIL upd_seen got %0d exp %0d", seen, 2 * (D - B)); end
  endtask

  task automatic test_enable();
    logic [15:0] e;
    int lit2 = 0;
    int pulses = 0;
    for (int k = 1; k <= 2 * F; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL en_sb empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if ({seg_out, an_out, frame_done} !== e) begin
          errors++;
          $display("FAIL en_sb k=%0d got %h/%h/%b exp %h/%h/%b", k, seg_out, an_out, frame_done, e[15:9], e[8:1], e[0]);
        end
      end
      if (k > F && an_out !== 8'hFF) begin
        lit2++;
        checks++;
        if (an_out inside {8'hFE, 8'hFB, 8'hEF, 8'hBF}) begin
          errors++;
          $display("FAIL en_dark k=%0d got an %h exp disabled digit dark", k, an_out);
        end
      end
      if (frame_done === 1'b1) pulses++;
      if (k == 1) digit_en = 8'b1010_1010;
    end
    checks++;
    if (lit2 != 4 * (D - B) || pulses != 2) begin
      errors++;
      $display("FAIL en_frame lit=%0d pulses=%0d exp %0d/2", lit2, pulses, 4 * (D - B));
    end
  endtask

  task automatic test_lamp();
    logic [15:0] e;
    for (int k = 1; k <= F; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL lamp_sb empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if ({seg_out, an_out, frame_done} !== e) begin
          errors++;
          $display("FAIL lamp_sb k=%0d got %h/%h/%b exp %h/%h/%b", k, seg_out, an_out, frame_done, e[15:9], e[8:1], e[0]);
        end
      end
      if (k == 29 || k == 30) begin
        checks++;
        if (an_out !== 8'hF7 || seg_out !== (k == 29 ? 7'h00 : 7'h43)) begin
          errors++;
          $display("FAIL lamp_seg k=%0d got %h/%h exp f7/%h", k, an_out, seg_out, k == 29 ? 7'h00 : 7'h43);
        end
      end
      if (k == 1) digit_en = 8'hFF;
      if (k == 28) lamp_test = 1'b1;
      if (k == 29) lamp_test = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    for (int k = 1; k <= 37 + F; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL rmid_sb empty k=%0d", k); end
      else begin
        e = exp_q.pop_front();
        if ({seg_out, an_out, frame_done} !== e) begin
          errors++;
          $display("FAIL rmid_sb k=%0d got %h/%h/%b exp %h/%h/%b", k, seg_out, an_out, frame_done, e[15:9], e[8:1], e[0]);
        end
      end
      if (k == 36 || k == 37 || k == 37 + 3 || (k > 37 && frame_done === 1'b1)) begin
        checks++;
        if (k == 36 && (an_out !== 8'hEF || seg_out !== 7'h44)) begin
          errors++; $display("FAIL rmid_pre got %h/%h exp ef/44", an_out, seg_out);
        end
        if (k == 37 && (an_out !== 8'hFF || seg_out !== 7'h7F || frame_done !== 1'b0)) begin
          errors++; $display("FAIL rmid_blank got %h/%h/%b exp ff/7f/0", an_out, seg_out, frame_done);
        end
        if (k == 40 && (an_out !== 8'hFE || seg_out !== 7'h55)) begin
          errors++; $display("FAIL rmid_restart got %h/%h exp fe/55", an_out, seg_out);
        end
        if (k > 37 && frame_done === 1'b1 && k != 37 + F) begin
          errors++; $display("FAIL rmid_fd k=%0d got pulse exp %0d", k, 37 + F);
        end
      end
      if (k == 36) begin rst_n = 1'b0; seg_in[0] = 7'h55; end
      if (k == 37) rst_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_done();
    test_mid_update();
    test_enable();
    test_lamp();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
